// File: rtl/iddmm_pkg.sv
// Shared types and default sizes for the IDDMM Montgomery datapath.
package iddmm_pkg;

    localparam int IDDMM_K = 128;
    localparam int IDDMM_N = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FILL,
        DRAIN
    } state_t;

    typedef logic [IDDMM_K-1:0] iddmm_word_t;

endpackage

// File: rtl/iddmm_word_buf.sv
// N x K word store with one write port and a registered, enable-gated read port.
module iddmm_word_buf #(
    parameter int K      = 128,
    parameter int N      = 16,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [K-1:0]      wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [K-1:0]      rd_data
);

    logic [K-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its word while rd_en is low, so a stalled output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/iddmm_result_sel.sv
// Final IDDMM stage: buffers the A and A-P streams, then drains the one picked by cal_sign.
// Optional sticky error reporting is enabled with `define IDDMM_RES_SEL_CHECK_EN.
module iddmm_result_sel
    import iddmm_pkg::*;
#(
    parameter int K      = IDDMM_K,
    parameter int N      = IDDMM_N,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_wr_en_a,
    input  logic [K-1:0]      fifo_wr_data_a,
    input  logic              fifo_wr_en_sub,
    input  logic [K-1:0]      fifo_wr_data_sub,
    input  logic              cal_done,
    input  logic              cal_sign,
    output logic              in_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [K-1:0]      res_data,
    output logic [ADDR_W-1:0] res_idx,
    output logic              res_last
`ifdef IDDMM_RES_SEL_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int                PTR_W    = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(N);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N - 1);

    state_t             state, state_nx;
    logic               sel;
    logic [PTR_W-1:0]   wp_a, wp_sub;
    logic               acc_a, acc_sub;
    logic               hs, hs_last, sel_full;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [K-1:0]       rd_a, rd_sub;

    assign in_ready = (state != DRAIN);
    assign acc_a    = fifo_wr_en_a   && in_ready && (wp_a   != PTR_FULL);
    assign acc_sub  = fifo_wr_en_sub && in_ready && (wp_sub != PTR_FULL);
    assign hs       = res_valid && res_ready;
    assign hs_last  = hs && res_last;
    assign sel_full = sel ? (wp_sub == PTR_FULL) : (wp_a == PTR_FULL);

    // Fetch word 0 on the first DRAIN cycle, then the next word on each non-final handshake.
    assign rd_en    = (state == DRAIN) && (!res_valid || (hs && !res_last));
    assign rd_addr  = res_valid ? (res_idx + ADDR_W'(1)) : '0;
    assign res_data = sel ? rd_sub : rd_a;

    iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_buf_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (acc_a),
        .wr_addr (wp_a[ADDR_W-1:0]),
        .wr_data (fifo_wr_data_a),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_a)
    );

    iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_buf_sub (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (acc_sub),
        .wr_addr (wp_sub[ADDR_W-1:0]),
        .wr_data (fifo_wr_data_sub),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_sub)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (cal_done) state_nx = WAIT_FILL;
            WAIT_FILL: if (sel_full) state_nx = DRAIN;
            DRAIN:     if (hs_last)  state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel    <= 1'b0;
            wp_a   <= '0;
            wp_sub <= '0;
        end else begin
            if ((state == IDLE) && cal_done) begin
                sel <= cal_sign;
            end
            if (hs_last) begin
                wp_a   <= '0;
                wp_sub <= '0;
            end else begin
                if (acc_a)   wp_a   <= wp_a + PTR_W'(1);
                if (acc_sub) wp_sub <= wp_sub + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_last  <= 1'b0;
        end else if (state == DRAIN) begin
            if (!res_valid) begin
                res_valid <= 1'b1;
                res_idx   <= '0;
                res_last  <= (IDX_LAST == '0);
            end else if (hs) begin
                if (res_last) begin
                    res_valid <= 1'b0;
                    res_idx   <= '0;
                    res_last  <= 1'b0;
                end else begin
                    res_idx   <= res_idx + ADDR_W'(1);
                    res_last  <= ((res_idx + ADDR_W'(1)) == IDX_LAST);
                end
            end
        end
    end

`ifdef IDDMM_RES_SEL_CHECK_EN
    logic chk_pending;
    logic drop;
    logic unsel_short;

    assign drop        = (fifo_wr_en_a && !acc_a) || (fifo_wr_en_sub && !acc_sub);
    assign unsel_short = sel ? (wp_a != PTR_FULL) : (wp_sub != PTR_FULL);

    // The unselected-stream check waits one cycle so a write coinciding with cal_done lands first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err         <= 1'b0;
            chk_pending <= 1'b0;
        end else begin
            chk_pending <= cal_done && (state == IDLE);
            if (drop || (cal_done && (state != IDLE)) || (chk_pending && unsel_short)) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iddmm_result_sel.sv
// Scoreboard bench for iddmm_result_sel: directed operations, monitor checks every presented word.
module tb_iddmm_result_sel;
    import iddmm_pkg::*;

    localparam int K  = 128;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_wr_en_a = 1'b0;
    logic [K-1:0]  fifo_wr_data_a = '0;
    logic          fifo_wr_en_sub = 1'b0;
    logic [K-1:0]  fifo_wr_data_sub = '0;
    logic          cal_done = 1'b0;
    logic          cal_sign = 1'b0;
    logic          in_ready;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [K-1:0]  res_data;
    logic [AW-1:0] res_idx;
    logic          res_last;
`ifdef IDDMM_RES_SEL_CHECK_EN
    logic          err;
`endif

    iddmm_result_sel #(.K(K), .N(N), .ADDR_W(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fifo_wr_en_a     (fifo_wr_en_a),
        .fifo_wr_data_a   (fifo_wr_data_a),
        .fifo_wr_en_sub   (fifo_wr_en_sub),
        .fifo_wr_data_sub (fifo_wr_data_sub),
        .cal_done         (cal_done),
        .cal_sign         (cal_sign),
        .in_ready         (in_ready),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_idx          (res_idx),
        .res_last         (res_last)
`ifdef IDDMM_RES_SEL_CHECK_EN
        ,
        .err              (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [K-1:0]  data;
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t         exp_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    logic         bp_mode = 1'b0;
    int           bp_cnt = 0;
    logic [K-1:0] mdl_a[N];
    logic [K-1:0] mdl_sub[N];
    int           mwp_a = 0;
    int           mwp_sub = 0;

    task automatic check_output(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Downstream ready: held high, or the 1,0,0,1 stall pattern when bp_mode is set.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            res_ready = ((bp_cnt % 4) == 0) || ((bp_cnt % 4) == 3);
            bp_cnt++;
        end else begin
            res_ready = 1'b1;
        end
    end

    // Monitor: every presented word must equal the head of the queue; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL unexpected_word: got idx %0d data %h, want no word", res_idx, res_data);
            end else begin
                if ({res_data, res_idx, res_last} !== exp_q[0]) begin
                    n_bad++;
                    $display("[TB] FAIL res_word: got data %h idx %0d last %0d, want data %h idx %0d last %0d",
                             res_data, res_idx, res_last, exp_q[0].data, exp_q[0].idx, exp_q[0].last);
                end
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cycle_write(input logic wa, input logic [K-1:0] da, input logic ws,
                               input logic [K-1:0] ds, input logic cd, input logic cs);
        fifo_wr_en_a     = wa;
        fifo_wr_data_a   = da;
        fifo_wr_en_sub   = ws;
        fifo_wr_data_sub = ds;
        cal_done         = cd;
        cal_sign         = cs;
        if (wa && mwp_a < N) begin
            mdl_a[mwp_a] = da;
            mwp_a++;
        end
        if (ws && mwp_sub < N) begin
            mdl_sub[mwp_sub] = ds;
            mwp_sub++;
        end
        @(posedge clk);
        #1;
        fifo_wr_en_a   = 1'b0;
        fifo_wr_en_sub = 1'b0;
        cal_done       = 1'b0;
    endtask

    task automatic push_expected(input logic s);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({(s ? mdl_sub[i] : mdl_a[i]), AW'(i), (i == N - 1)});
        end
        mwp_a   = 0;
        mwp_sub = 0;
    endtask

    // Writes both streams in lockstep; cal_done rides on the last sub write.
    task automatic apply_stimulus(input logic [K-1:0] a_off, input int na,
                                  input logic [K-1:0] sub_off, input int nsub, input logic s);
        int ncyc;
        ncyc = (na > nsub) ? na : nsub;
        for (int i = 0; i < ncyc; i++) begin
            cycle_write(i < na, a_off + K'(i + 1), i < nsub, sub_off + K'(i + 1), i == nsub - 1, s);
        end
        push_expected(s);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || res_valid) && t < 300) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= 300) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL %s_timeout: got %0d words pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
        check_output({name, "_in_ready"}, K'(in_ready), K'(1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_in_ready", K'(in_ready), K'(1));
        check_output("rst_res_valid", K'(res_valid), K'(0));
        check_output("rst_res_data", res_data, K'(0));
        check_output("rst_res_idx", K'(res_idx), K'(0));
        check_output("rst_res_last", K'(res_last), K'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic sub select");
        apply_stimulus(K'(0), 16, K'('h100), 16, 1'b1);
        wait_drain("basic_sub");

        $display("[TB] A select");
        apply_stimulus(K'(0), 16, K'('h100), 16, 1'b0);
        wait_drain("sel_a");

        $display("[TB] backpressure");
        bp_cnt  = 0;
        bp_mode = 1'b1;
        apply_stimulus(K'('h1000), 16, K'('h2000), 16, 1'b1);
        wait_drain("backpressure");
        bp_mode = 1'b0;

        $display("[TB] late fill");
        begin
            int cyc;
            for (int i = 0; i < 14; i++) begin
                cycle_write(1'b1, K'('h300 + i + 1), 1'b1, K'('h400 + i + 1), 1'b0, 1'b0);
            end
            cycle_write(1'b1, K'('h30F), 1'b0, '0, 1'b0, 1'b0);
            cycle_write(1'b1, K'('h310), 1'b0, '0, 1'b1, 1'b1);
            cycle_write(1'b0, '0, 1'b1, K'('h40F), 1'b0, 1'b0);
            cycle_write(1'b0, '0, 1'b1, K'('h410), 1'b0, 1'b0);
            push_expected(1'b1);
            cyc = 0;
            while (!res_valid && cyc < 10) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check_output("late_fill_latency", K'(cyc), K'(2));
            check_output("drain_in_ready", K'(in_ready), K'(0));
            wait_drain("late_fill");
        end
`ifdef IDDMM_RES_SEL_CHECK_EN
        check_output("err_clean", K'(err), K'(0));
`endif

        $display("[TB] overflow and write during drain");
        apply_stimulus(K'(0), 17, K'('h500), 16, 1'b0);
        begin
            int t;
            t = 0;
            while (!res_valid && t < 20) begin
                @(posedge clk);
                #1;
                t++;
            end
            fifo_wr_en_a     = 1'b1;
            fifo_wr_data_a   = K'('hBAD);
            fifo_wr_en_sub   = 1'b1;
            fifo_wr_data_sub = K'('hBAD);
            @(posedge clk);
            #1;
            fifo_wr_en_a   = 1'b0;
            fifo_wr_en_sub = 1'b0;
        end
        wait_drain("overflow");
`ifdef IDDMM_RES_SEL_CHECK_EN
        check_output("err_set", K'(err), K'(1));
        repeat (3) @(posedge clk);
        #1;
        check_output("err_sticky", K'(err), K'(1));
        rst_n = 1'b0;
        #2;
        check_output("err_cleared", K'(err), K'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`endif

        $display("[TB] reset mid drain");
        apply_stimulus(K'('h600), 16, K'('h700), 16, 1'b1);
        begin
            int t;
            t = 0;
            while (!(res_valid && res_ready && res_idx == AW'(5)) && t < 100) begin
                @(posedge clk);
                #2;
                t++;
            end
            if (t >= 100) begin
                n_vec++;
                n_bad++;
                $display("[TB] FAIL mid_drain_idx5: got no idx 5 handshake, want one");
            end
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check_output("mid_rst_res_valid", K'(res_valid), K'(0));
            check_output("mid_rst_in_ready", K'(in_ready), K'(1));
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
        apply_stimulus(K'('h800), 16, K'('h900), 16, 1'b0);
        wait_drain("after_reset");
`ifdef IDDMM_RES_SEL_CHECK_EN
        check_output("err_final", K'(err), K'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no completion, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
